// File: rtl/acc_processor_pkg.sv
// Shared opcode and FSM-state definitions for the acc_processor accumulator CPU.
package acc_processor_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_LDR  = 4'h2;
    localparam logic [OPC_W-1:0] OP_STR  = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h5;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h6;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'h7;
    localparam logic [OPC_W-1:0] OP_IN   = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hB;
    localparam logic [OPC_W-1:0] OP_JN   = 4'hC;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hD;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_OPER,
        ST_EXEC,
        ST_WAIT_KEY,
        ST_HALT
    } state_t;

    // Ops whose operand lives in the following ROM word.
    function automatic logic is_two_word(input logic [OPC_W-1:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JN);
    endfunction

endpackage

// File: rtl/acc_processor_alu.sv
// Combinational ALU for acc_processor: {ah,acc} result plus zero/sign flags.
// The multiplier exists only when ACC_PROCESSOR_MUL_EN is defined.
module acc_alu
    import acc_processor_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [OPC_W-1:0]    i_op,
    input  logic [DATA_W-1:0]   i_acc,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_res,
    output logic                o_z,
    output logic                o_s
);

    logic [DATA_W-1:0] w_lo;

`ifdef ACC_PROCESSOR_MUL_EN
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod = {{DATA_W{1'b0}}, i_acc} * {{DATA_W{1'b0}}, i_b};
`endif

    always_comb begin
        w_lo  = i_acc;
        o_res = '0;
        case (i_op)
            OP_LDI, OP_LDR: w_lo = i_b;
            OP_ADD:         w_lo = i_acc + i_b;
            OP_SUB:         w_lo = i_acc - i_b;
            OP_AND:         w_lo = i_acc & i_b;
            default:        w_lo = i_acc;
        endcase
        o_res = {{DATA_W{1'b0}}, w_lo};
`ifdef ACC_PROCESSOR_MUL_EN
        if (i_op == OP_MUL) o_res = w_prod;
`endif
        o_z = (o_res[DATA_W-1:0] == '0);
        o_s = o_res[DATA_W-1];
    end

endmodule

// File: rtl/acc_processor.sv
// Multi-cycle accumulator CPU: FETCH/OPER/EXEC/WAIT_KEY/HALT over an async-read ROM.
// Define ACC_PROCESSOR_MUL_EN to enable the MUL opcode; otherwise opcode 7 is a NOP.
module acc_processor
    import acc_processor_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int NREG    = 4
) (
    input  logic                clk,
    input  logic                clr,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                rom_en,
    input  logic [INSTR_W-1:0]  rom_data,
    input  logic [DATA_W-1:0]   key_data,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_valid,
    output logic                halted
);

    localparam int RW = $clog2(NREG);

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir, r_opnd;
    logic [DATA_W-1:0]   r_acc, r_ah;
    logic                r_z, r_s;
    logic [2*DATA_W-1:0] r_out_data;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_regs [NREG];

    logic [OPC_W-1:0]    w_opc, w_fetch_opc;
    logic [RW-1:0]       w_rsel;
    logic [DATA_W-1:0]   w_reg_rd, w_alu_b;
    logic [2*DATA_W-1:0] w_alu_res;
    logic                w_alu_z, w_alu_s;
    logic                w_acc_we, w_branch;
    logic [NREG-1:0]     w_reg_we;
    logic                w_unused_bits;

    assign w_opc         = r_ir[INSTR_W-1 -: OPC_W];
    assign w_fetch_opc   = rom_data[INSTR_W-1 -: OPC_W];
    assign w_rsel        = r_ir[RW-1:0];
    assign w_reg_rd      = r_regs[w_rsel];
    assign w_alu_b       = (w_opc == OP_LDI) ? r_opnd[DATA_W-1:0] : w_reg_rd;
    assign w_branch      = (w_opc == OP_JMP) || ((w_opc == OP_JZ) && r_z) || ((w_opc == OP_JN) && r_s);
    assign w_unused_bits = ^{r_ir, r_opnd};

    assign rom_addr  = r_pc;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    acc_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op  (w_opc),
        .i_acc (r_acc),
        .i_b   (w_alu_b),
        .o_res (w_alu_res),
        .o_z   (w_alu_z),
        .o_s   (w_alu_s)
    );

    always_comb begin
        w_acc_we = 1'b0;
        case (w_opc)
            OP_LDI, OP_LDR, OP_ADD, OP_SUB, OP_AND: w_acc_we = 1'b1;
`ifdef ACC_PROCESSOR_MUL_EN
            OP_MUL: w_acc_we = 1'b1;
`endif
            default: w_acc_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= ST_FETCH;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        rom_en       = 1'b0;
        key_ready    = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                rom_en       = 1'b1;
                w_state_next = is_two_word(w_fetch_opc) ? ST_OPER : ST_EXEC;
            end
            ST_OPER: begin
                rom_en       = 1'b1;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_opc == OP_IN)        w_state_next = ST_WAIT_KEY;
                else if (w_opc == OP_HALT) w_state_next = ST_HALT;
                else                       w_state_next = ST_FETCH;
            end
            ST_WAIT_KEY: begin
                key_ready = 1'b1;
                if (key_valid) w_state_next = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: w_state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_ah        <= '0;
            r_z         <= 1'b1;
            r_s         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    r_ir <= rom_data;
                    r_pc <= r_pc + ADDR_W'(1);
                end
                ST_OPER: begin
                    r_opnd <= rom_data;
                    r_pc   <= r_pc + ADDR_W'(1);
                end
                ST_EXEC: begin
                    if (w_acc_we) begin
                        {r_ah, r_acc} <= w_alu_res;
                        r_z           <= w_alu_z;
                        r_s           <= w_alu_s;
                    end
                    if (w_opc == OP_OUT) begin
                        r_out_data  <= {r_ah, r_acc};
                        r_out_valid <= 1'b1;
                    end
                    // Untaken branches leave pc pointing past the operand word.
                    if (w_branch) r_pc <= r_opnd[ADDR_W-1:0];
                end
                ST_WAIT_KEY: begin
                    if (key_valid) begin
                        r_acc <= key_data;
                        r_ah  <= '0;
                        r_z   <= (key_data == '0);
                        r_s   <= key_data[DATA_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg_we
            assign w_reg_we[gi] = (r_state == ST_EXEC) && (w_opc == OP_STR) && (w_rsel == RW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_reg_we[i]) r_regs[i] <= r_acc;
            end
        end
    end

endmodule
